// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-side signal bundle for the hazard/stall sequencer.
// Revision    : 1.0
// ============================================================================
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

interface hazard_ctrl_if #(
    parameter int PC_W  = `PC_WIDTH,
    parameter int CNT_W = 16
);
    logic [4:0]      i_id_rs;
    logic [4:0]      i_id_rt;
    logic            i_id_uses_rt;
    logic            i_ex_mem_read;
    logic [4:0]      i_ex_rd;
    logic            i_ex_change_pc;
    logic [PC_W-1:0] i_ex_alu_pc;
    logic            i_mem_busy;
    logic            i_cnt_clr;

    logic             o_pc_we;
    logic             o_if_id_we;
    logic             o_id_ex_we;
    logic             o_ex_mem_we;
    logic             o_if_id_flush;
    logic             o_id_ex_flush;
    logic             o_redirect_valid;
    logic [PC_W-1:0]  o_redirect_pc;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;
    logic             o_busy;

    modport slave (
        input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rd,
               i_ex_change_pc, i_ex_alu_pc, i_mem_busy, i_cnt_clr,
        output o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we, o_if_id_flush,
               o_id_ex_flush, o_redirect_valid, o_redirect_pc, o_stall_cnt,
               o_flush_cnt, o_busy
    );

    modport master (
        output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rd,
               i_ex_change_pc, i_ex_alu_pc, i_mem_busy, i_cnt_clr,
        input  o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we, o_if_id_flush,
               o_id_ex_flush, o_redirect_valid, o_redirect_pc, o_stall_cnt,
               o_flush_cnt, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : 5-stage pipeline sequencer: redirect/squash, load-use bubbles,
//               memory freeze and saturating stall/flush counters.
// Revision    : 1.0
// ============================================================================
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module hazard_ctrl #(
    parameter int PC_W     = `PC_WIDTH,
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 16
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    hazard_ctrl_if.slave     if_hz
);
    localparam logic [2:0]       c_LU_INIT = 3'(LU_STALL - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_WAIT  = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_lu_cnt, w_lu_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic            w_hz;
    logic            w_pc_we, w_if_id_we, w_id_ex_we, w_ex_mem_we;
    logic            w_if_id_flush, w_id_ex_flush, w_redirect;
    logic [PC_W-1:0] w_redirect_pc;

    assign w_hz = if_hz.i_ex_mem_read && (if_hz.i_ex_rd != 5'd0) &&
                  ((if_hz.i_ex_rd == if_hz.i_id_rs) ||
                   (if_hz.i_id_uses_rt && (if_hz.i_ex_rd == if_hz.i_id_rt)));

    always_comb begin
        w_pc_we       = 1'b0;
        w_if_id_we    = 1'b0;
        w_id_ex_we    = 1'b0;
        w_ex_mem_we   = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        w_state_nxt   = r_state;
        w_lu_cnt_nxt  = r_lu_cnt;

        // Everything stays quiet while reset is held, even mid-cycle.
        if (i_rst_n) begin
            if (if_hz.i_mem_busy) begin
                if (r_state != S_LU_WAIT) begin
                    w_state_nxt = S_MEM_WAIT;
                end
            end else if (if_hz.i_ex_change_pc) begin
                w_pc_we       = 1'b1;
                w_if_id_we    = 1'b1;
                w_id_ex_we    = 1'b1;
                w_ex_mem_we   = 1'b1;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                w_redirect    = 1'b1;
                w_redirect_pc = if_hz.i_ex_alu_pc;
                w_lu_cnt_nxt  = 3'd0;
                w_state_nxt   = S_RUN;
            end else if ((r_state == S_LU_WAIT) || w_hz) begin
                w_id_ex_we    = 1'b1;
                w_id_ex_flush = 1'b1;
                w_ex_mem_we   = 1'b1;
                if (r_state == S_LU_WAIT) begin
                    w_lu_cnt_nxt = r_lu_cnt - 3'd1;
                    if (r_lu_cnt == 3'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end else if (LU_STALL > 1) begin
                    w_lu_cnt_nxt = c_LU_INIT;
                    w_state_nxt  = S_LU_WAIT;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end else begin
                w_pc_we     = 1'b1;
                w_if_id_we  = 1'b1;
                w_id_ex_we  = 1'b1;
                w_ex_mem_we = 1'b1;
                w_state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_RUN;
            r_lu_cnt <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (if_hz.i_cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_we && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redirect && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign if_hz.o_pc_we          = w_pc_we;
    assign if_hz.o_if_id_we       = w_if_id_we;
    assign if_hz.o_id_ex_we       = w_id_ex_we;
    assign if_hz.o_ex_mem_we      = w_ex_mem_we;
    assign if_hz.o_if_id_flush    = w_if_id_flush;
    assign if_hz.o_id_ex_flush    = w_id_ex_flush;
    assign if_hz.o_redirect_valid = w_redirect;
    assign if_hz.o_redirect_pc    = w_redirect_pc;
    assign if_hz.o_stall_cnt      = r_stall_cnt;
    assign if_hz.o_flush_cnt      = r_flush_cnt;
    assign if_hz.o_busy           = (r_state != S_RUN);
endmodule
`default_nettype wire
